// File: rtl/iso_tu_scheduler.sv
// Transfer-unit slot scheduler: maps each link-symbol cycle to a data, fill, FS or FE slot,
// spreading a fractional valid-symbol rate across TUs with a 1/256 accumulator.
module iso_tu_scheduler #(
   parameter int TU_SIZE = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       cfg_load,
   input  logic [5:0] cfg_vld_sym,
   input  logic [7:0] cfg_frac,
   input  logic       fifo_empty,
   output logic [1:0] tu_sel,
   output logic       tu_rd_req,
   output logic       tu_start,
   output logic [5:0] tu_slot,
   output logic       tu_underflow
);

   localparam logic [5:0] LAST_SLOT = 6'(TU_SIZE - 1);
   localparam logic [1:0] SEL_FILL  = 2'b00;
   localparam logic [1:0] SEL_DATA  = 2'b01;
   localparam logic [1:0] SEL_FS    = 2'b10;
   localparam logic [1:0] SEL_FE    = 2'b11;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t     state;
   logic [5:0] lat_int;
   logic [7:0] lat_frac;
   logic [5:0] pend_int;
   logic [7:0] pend_frac;
   logic       pend_vld;
   logic [7:0] acc;
   logic [5:0] count;

   logic [5:0] eff_int;
   logic [7:0] eff_frac;
   logic [7:0] acc_base;
   logic [8:0] sum;
   logic [5:0] new_count;
   logic       wrap;
   logic       advance;
   logic [5:0] slot_nxt;
   logic [5:0] count_use;
   logic       data_nxt;
   logic [1:0] sel_nxt;

   function automatic logic [5:0] clamp_int(input logic [5:0] v);
      if (v == 6'd0)
         return 6'd1;
      else if (v > 6'd60)
         return 6'd60;
      else
         return v;
   endfunction

   // A new TU begins either from IDLE or after slot 63; both consume the pending config.
   always_comb begin
      eff_int  = pend_vld ? pend_int  : lat_int;
      eff_frac = pend_vld ? pend_frac : lat_frac;
      if (state == IDLE && cfg_load) begin
         eff_int  = clamp_int(cfg_vld_sym);
         eff_frac = cfg_frac;
      end
      wrap      = (state == IDLE) || (tu_slot == LAST_SLOT);
      acc_base  = (state == IDLE) ? 8'd0 : acc;
      sum       = {1'b0, acc_base} + {1'b0, eff_frac};
      new_count = eff_int + {5'd0, sum[8]};
      advance   = en || (state != IDLE && tu_slot != LAST_SLOT);
      slot_nxt  = wrap ? 6'd0 : tu_slot + 6'd1;
      count_use = wrap ? new_count : count;
      data_nxt  = slot_nxt < count_use;
      if (data_nxt)
         sel_nxt = fifo_empty ? SEL_FILL : SEL_DATA;
      else if (slot_nxt == count_use)
         sel_nxt = SEL_FS;
      else if (slot_nxt == LAST_SLOT)
         sel_nxt = SEL_FE;
      else
         sel_nxt = SEL_FILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lat_int      <= 6'd1;
         lat_frac     <= 8'd0;
         pend_int     <= 6'd1;
         pend_frac    <= 8'd0;
         pend_vld     <= 1'b0;
         acc          <= 8'd0;
         count        <= 6'd1;
         tu_sel       <= SEL_FILL;
         tu_rd_req    <= 1'b0;
         tu_start     <= 1'b0;
         tu_slot      <= 6'd0;
         tu_underflow <= 1'b0;
      end else begin
         if (advance && wrap) begin
            lat_int  <= eff_int;
            lat_frac <= eff_frac;
            pend_vld <= 1'b0;
            acc      <= sum[7:0];
            count    <= new_count;
         end
         // A load in IDLE is immediate; otherwise it waits for the next TU boundary.
         if (cfg_load) begin
            if (state == IDLE) begin
               lat_int  <= clamp_int(cfg_vld_sym);
               lat_frac <= cfg_frac;
               pend_vld <= 1'b0;
            end else begin
               pend_int  <= clamp_int(cfg_vld_sym);
               pend_frac <= cfg_frac;
               pend_vld  <= 1'b1;
            end
         end
         if (advance) begin
            state        <= en ? ACTIVE : DRAIN;
            tu_slot      <= slot_nxt;
            tu_start     <= (slot_nxt == 6'd0);
            tu_sel       <= sel_nxt;
            tu_rd_req    <= data_nxt && !fifo_empty;
            tu_underflow <= ((state == IDLE) ? 1'b0 : tu_underflow) | (data_nxt && fifo_empty);
         end else begin
            state     <= IDLE;
            tu_slot   <= 6'd0;
            tu_start  <= 1'b0;
            tu_sel    <= SEL_FILL;
            tu_rd_req <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iso_tu_scheduler.sv
// Directed bench for iso_tu_scheduler: walks whole TUs slot by slot against hand-derived slot maps.
module tb_iso_tu_scheduler;

   localparam int NONE = -9;
   localparam int NEVER = 99;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       cfg_load;
   logic [5:0] cfg_vld_sym;
   logic [7:0] cfg_frac;
   logic       fifo_empty;
   logic [1:0] tu_sel;
   logic       tu_rd_req;
   logic       tu_start;
   logic [5:0] tu_slot;
   logic       tu_underflow;

   int errors = 0;
   int checks = 0;

   iso_tu_scheduler #(.TU_SIZE(64)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load),
      .cfg_vld_sym(cfg_vld_sym), .cfg_frac(cfg_frac), .fifo_empty(fifo_empty),
      .tu_sel(tu_sel), .tu_rd_req(tu_rd_req), .tu_start(tu_start),
      .tu_slot(tu_slot), .tu_underflow(tu_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " sel"},   32'(tu_sel), 32'd0);
      check({tag, " rd"},    32'(tu_rd_req), 32'd0);
      check({tag, " start"}, 32'(tu_start), 32'd0);
      check({tag, " slot"},  32'(tu_slot), 32'd0);
   endtask

   // Drives one TU (64 edges) and checks every slot; en is low for slots low+1..high,
   // fifo_empty is high while slot empty_slot is produced, cfg_load is pulsed while slot load_slot shows.
   task automatic run_tu(input int cnt, input int empty_slot, input int low, input int high,
                         input int load_slot, input int ld_vld, input int ld_frac);
      int rd = 0;
      int exp_sel;
      logic exp_rd;
      for (int s = 0; s < 64; s++) begin
         en         = !(s > low && s <= high);
         fifo_empty = (s == empty_slot);
         cfg_load   = (s == load_slot + 1);
         if (s == load_slot + 1) begin
            cfg_vld_sym = ld_vld[5:0];
            cfg_frac    = ld_frac[7:0];
         end
         step();
         cfg_load   = 1'b0;
         fifo_empty = 1'b0;
         if (s < cnt)
            exp_sel = (s == empty_slot) ? 0 : 1;
         else if (s == cnt)
            exp_sel = 2;
         else if (s == 63)
            exp_sel = 3;
         else
            exp_sel = 0;
         exp_rd = (s < cnt) && (s != empty_slot);
         check($sformatf("tu%0d slot%0d", cnt, s),
               32'({tu_slot, tu_sel, tu_rd_req, tu_start}),
               32'({s[5:0], exp_sel[1:0], exp_rd, (s == 0)}));
         rd += int'(tu_rd_req);
      end
      check($sformatf("tu%0d rd_count", cnt), 32'(rd),
            32'(cnt - ((empty_slot >= 0 && empty_slot < cnt) ? 1 : 0)));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; fifo_empty = 1'b0;
      cfg_vld_sym = 6'd0; cfg_frac = 8'd0;
      #12;
      check_idle("reset");
      check("reset underflow", 32'(tu_underflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      check_idle("idle wait");

      // Integer rate 10, loaded while idle
      cfg_vld_sym = 6'd10; cfg_frac = 8'd0; cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      check_idle("idle load");
      run_tu(10, NONE, NEVER, NEVER, NONE, 0, 0);
      run_tu(10, NONE, NEVER, NEVER, NONE, 0, 0);

      // Mid-TU reload only affects the next TU
      run_tu(10, NONE, NEVER, NEVER, 5, 20, 0);
      run_tu(20, NONE, NEVER, NEVER, NONE, 0, 0);

      // Half-symbol fraction alternates 10 and 11
      run_tu(20, NONE, NEVER, NEVER, 30, 10, 128);
      run_tu(10, NONE, NEVER, NEVER, NONE, 0, 0);
      run_tu(11, NONE, NEVER, NEVER, NONE, 0, 0);
      run_tu(10, NONE, NEVER, NEVER, NONE, 0, 0);
      run_tu(11, NONE, NEVER, NEVER, NONE, 0, 0);

      // Underflow on slot 3, sticky across TUs
      run_tu(10, 3, NEVER, NEVER, NONE, 0, 0);
      check("underflow set", 32'(tu_underflow), 32'd1);
      run_tu(11, NONE, NEVER, NEVER, NONE, 0, 0);
      check("underflow sticky", 32'(tu_underflow), 32'd1);

      // en drops at slot 20: TU completes, then IDLE
      run_tu(10, NONE, 20, NEVER, NONE, 0, 0);
      step();
      check_idle("drain end");
      check("underflow kept in idle", 32'(tu_underflow), 32'd1);
      step();
      check_idle("idle hold");

      // Restart clears accumulator and underflow; drain/re-assert keeps accumulator
      run_tu(10, NONE, 20, 40, NONE, 0, 0);
      check("underflow cleared", 32'(tu_underflow), 32'd0);
      run_tu(11, NONE, NEVER, NEVER, NONE, 0, 0);
      run_tu(10, NONE, NEVER, NEVER, NONE, 0, 0);

      // Asynchronous reset mid-TU
      for (int i = 0; i < 31; i++) step();
      check("pre-reset slot", 32'(tu_slot), 32'd30);
      #2 rst_n = 1'b0;
      #1;
      check_idle("async reset");
      check("async reset underflow", 32'(tu_underflow), 32'd0);
      en = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      check_idle("post reset");

      // cfg_vld_sym=0 behaves as 1, then 63/255 clamps to 60 with carries
      cfg_vld_sym = 6'd0; cfg_frac = 8'd0; cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      run_tu(1, NONE, NEVER, NEVER, 2, 63, 255);
      run_tu(60, NONE, NEVER, NEVER, NONE, 0, 0);
      run_tu(61, NONE, NEVER, NEVER, NONE, 0, 0);
      run_tu(61, NONE, 50, NEVER, NONE, 0, 0);
      step();
      check_idle("final idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
